strobe_period_meter: RTL and testbench

Receive-side companion to the strobe counter: counts `enable` ticks between successive `strobe_in` pulses and recovers the divider ratio that produced them. Each completed interval is presented as a registered `period` measurement on a valid/ready output. A small lock state machine flags when the measured ratio has been stable for `LOCK_COUNT` consecutive intervals. It sits downstream of any strobe source, for ratio checking, rate recovery and link monitoring.

---
 rtl/strobe_period_meter.sv | 132 +++++++++++++
 tb/tb_strobe_period_meter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/strobe_period_meter.sv
// rtl/strobe_period_meter.sv - measures enable ticks between strobes and tracks ratio lock
module strobe_period_meter #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             missed,
  output logic             locked
);

  localparam logic [WIDTH-1:0] TICK_MAX = '1;
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] tick_q;
  logic             ovf_pend_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             overflow_q;
  logic             missed_q;
  logic             locked_q;
  logic [WIDTH-1:0] prev_q;
  logic             ref_valid_q;
  logic [3:0]       match_q;
  logic [3:0]       match_d;

  // Tick counter: a strobe closes the interval and seeds the next one with
  // this cycle's enable; a tick arriving while saturated marks the interval
  // as overflowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= '0;
      ovf_pend_q <= 1'b0;
    end else if (strobe_in) begin
      tick_q     <= WIDTH'(enable);
      ovf_pend_q <= 1'b0;
    end else if (enable) begin
      if (tick_q == TICK_MAX) begin
        ovf_pend_q <= 1'b1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  // Match count for the interval being closed: an overflow breaks the chain
  // and drops the reference, the first clean measurement with no reference
  // counts as one, otherwise equal values extend the count and a change
  // clears it.
  always_comb begin
    match_d = match_q;
    if (ovf_pend_q) begin
      match_d = 4'd0;
    end else if (!ref_valid_q) begin
      match_d = 4'd1;
    end else if (tick_q == prev_q) begin
      match_d = (match_q >= LOCK_CNT) ? LOCK_CNT : match_q + 4'd1;
    end else begin
      match_d = 4'd0;
    end
  end

  // Lock FSM with registered measurement outputs and valid/ready holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      missed_q       <= 1'b0;
      locked_q       <= 1'b0;
      prev_q         <= '0;
      ref_valid_q    <= 1'b0;
      match_q        <= 4'd0;
    end else begin
      missed_q <= 1'b0;
      if (period_valid_q && period_ready) begin
        period_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          // The first strobe only establishes the reference boundary.
          if (strobe_in) begin
            state_q <= S_ACQUIRE;
          end
        end
        S_ACQUIRE, S_LOCKED: begin
          if (strobe_in) begin
            period_q       <= tick_q;
            overflow_q     <= ovf_pend_q;
            period_valid_q <= 1'b1;
            missed_q       <= period_valid_q && !period_ready;
            prev_q         <= tick_q;
            ref_valid_q    <= !ovf_pend_q;
            match_q        <= match_d;
            if (match_d == LOCK_CNT) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= S_ACQUIRE;
              locked_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overflow     = overflow_q;
  assign missed       = missed_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// tb/tb_strobe_period_meter.sv - self-checking bench for strobe_period_meter
module tb_strobe_period_meter;

  localparam int WIDTH      = 4;
  localparam int LOCK_COUNT = 2;
  localparam int TMAX       = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             strobe_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_ready;
  logic             overflow;
  logic             missed;
  logic             locked;

  int errors = 0;
  int checks = 0;

  strobe_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .strobe_in   (strobe_in),
    .period      (period),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .overflow    (overflow),
    .missed      (missed),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unbounded tick count, history of clean measurements.
  bit m_seen;
  int m_ticks;
  int m_hist[$];
  int m_period;
  bit m_valid;
  bit m_ovf;
  bit m_missed;
  bit m_locked;

  task automatic model_reset();
    m_seen = 0; m_ticks = 0; m_hist.delete();
    m_period = 0; m_valid = 0; m_ovf = 0; m_missed = 0; m_locked = 0;
  endtask

  // Trailing run of equal values; a run that reaches back to the reference
  // point counts every member, otherwise the first member only anchors it.
  function automatic int lock_score();
    int n;
    int r;
    n = m_hist.size();
    if (n == 0) return 0;
    r = 1;
    for (int i = n - 2; i >= 0; i--) begin
      if (m_hist[i] != m_hist[n-1]) break;
      r++;
    end
    return (r == n) ? r : r - 1;
  endfunction

  task automatic model_edge(input bit e, input bit s, input bit r);
    m_missed = 0;
    if (s) begin
      if (m_seen) begin
        m_missed = m_valid && !r;
        m_valid  = 1;
        m_ovf    = (m_ticks > TMAX);
        m_period = m_ovf ? TMAX : m_ticks;
        if (m_ovf) m_hist.delete();
        else m_hist.push_back(m_period);
        m_locked = (lock_score() >= LOCK_COUNT);
      end else if (m_valid && r) begin
        m_valid = 0;
      end
      m_seen  = 1;
      m_ticks = e ? 1 : 0;
    end else begin
      if (m_valid && r) m_valid = 0;
      if (e) m_ticks++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_period", int'(period), m_period);
    check("model_valid", int'(period_valid), int'(m_valid));
    check("model_overflow", int'(overflow), int'(m_ovf));
    check("model_missed", int'(missed), int'(m_missed));
    check("model_locked", int'(locked), int'(m_locked));
  endtask

  task automatic step(input bit e, input bit s, input bit r);
    enable = e; strobe_in = s; period_ready = r;
    @(posedge clk);
    model_edge(e, s, r);
    #1;
    check_model();
  endtask

  // n enables on alternate cycles, strobe on the cycle after the last one.
  task automatic run_interval(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, r);
      step(1'b0, (i == n - 1), r);
    end
    if (n == 0) step(1'b0, 1'b1, r);
  endtask

  typedef struct {
    int n_en;
    int exp_period;
    bit exp_valid;
    bit exp_ovf;
    bit exp_locked;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{3,  0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{5,  5,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{5,  5,  1'b1, 1'b0, 1'b1};
    tbl[3] = '{5,  5,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{6,  6,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{6,  6,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{6,  6,  1'b1, 1'b0, 1'b1};
    tbl[7] = '{20, 15, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{5,  5,  1'b1, 1'b0, 1'b0};
    tbl[9] = '{5,  5,  1'b1, 1'b0, 1'b1};

    rst = 1'b1; enable = 1'b0; strobe_in = 1'b0; period_ready = 1'b1;
    model_reset();
    #1;
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(period_valid), 0);
    check("reset_locked", int'(locked), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed interval table.
    foreach (tbl[k]) begin
      run_interval(tbl[k].n_en, 1'b1);
      check($sformatf("tbl%0d_period", k), int'(period), tbl[k].exp_period);
      check($sformatf("tbl%0d_valid", k), int'(period_valid), int'(tbl[k].exp_valid));
      check($sformatf("tbl%0d_ovf", k), int'(overflow), int'(tbl[k].exp_ovf));
      check($sformatf("tbl%0d_locked", k), int'(locked), int'(tbl[k].exp_locked));
    end

    // Unconsumed measurement overwritten, then consumed late.
    run_interval(5, 1'b0);
    check("hold5_valid", int'(period_valid), 1);
    run_interval(7, 1'b0);
    check("ovwr_period", int'(period), 7);
    check("ovwr_missed", int'(missed), 1);
    step(1'b0, 1'b0, 1'b0);
    check("ovwr_missed_pulse", int'(missed), 0);
    check("ovwr_valid_held", int'(period_valid), 1);
    step(1'b0, 1'b0, 1'b1);
    check("ovwr_valid_drop", int'(period_valid), 0);

    // Strobe coincident with enable, then back-to-back strobes.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("coinc_period", int'(period), 4);
    step(1'b0, 1'b1, 1'b1);
    check("zero_period", int'(period), 0);
    check("zero_valid", int'(period_valid), 1);

    // Asynchronous reset while locked.
    for (int i = 0; i < 3; i++) run_interval(5, 1'b1);
    check("prerst_locked", int'(locked), 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_period", int'(period), 0);
    check("arst_valid", int'(period_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_overflow", int'(overflow), 0);
    #1 rst = 1'b0;
    run_interval(5, 1'b1);
    check("postrst_ref_valid", int'(period_valid), 0);
    run_interval(5, 1'b1);
    check("postrst_period", int'(period), 5);
    check("postrst_valid", int'(period_valid), 1);

    // Random traffic against the model: short then long intervals.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), ($urandom_range(0, 1) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
